// File: rtl/pad_ctrl_pkg.sv
// Shared definitions for the pad ring controller: config word layout and reset value.
package pad_ctrl_pkg;

  localparam int CFG_MODE   = 0;
  localparam int CFG_SW_OUT = 1;
  localparam int CFG_SW_OE  = 2;
  localparam int CFG_CS     = 3;
  localparam int CFG_SL     = 4;
  localparam int CFG_IE     = 5;
  localparam int CFG_PU     = 6;
  localparam int CFG_PD     = 7;

  localparam logic [7:0] CFG_RESET = 8'h20;
  localparam int ADDR_W = 8;

  typedef struct packed {
    logic pd;
    logic pu;
    logic ie;
    logic sl;
    logic cs;
    logic sw_oe;
    logic sw_out;
    logic mode;
  } pad_cfg_t;

  // Pull-down wins when software asks for both pulls at once.
  function automatic pad_cfg_t sanitize_cfg(input logic [7:0] w);
    logic [7:0] c;
    c = w;
    if (w[CFG_PU] && w[CFG_PD]) c[CFG_PU] = 1'b0;
    return pad_cfg_t'(c);
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Per-pad input synchroniser with previous-value flop and gated edge detection.
module pad_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_in,
  input  logic ie,
  input  logic edge_en,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_reg & ie & edge_en;
  assign fall     = ~sync_out & prev_reg & ie & edge_en;

endmodule

// File: rtl/pad_ctrl.sv
// Core-side pad ring controller: per-pad config registers, registered pad drive,
// and synchronised inputs with edge pulses.
module pad_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int NUM_BIDIR   = 54,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reg_valid,
  output logic                 reg_ready,
  input  logic                 reg_we,
  input  logic [ADDR_W-1:0]    reg_addr,
  input  logic [7:0]           reg_wdata,
  output logic [7:0]           reg_rdata,
  output logic                 reg_rvalid,
  input  logic [NUM_BIDIR-1:0] func_out,
  input  logic [NUM_BIDIR-1:0] func_oe,
  output logic [NUM_BIDIR-1:0] gpio_in,
  output logic [NUM_BIDIR-1:0] rise,
  output logic [NUM_BIDIR-1:0] fall,
  input  logic [NUM_BIDIR-1:0] bidir_in,
  output logic [NUM_BIDIR-1:0] bidir_out,
  output logic [NUM_BIDIR-1:0] bidir_oe,
  output logic [NUM_BIDIR-1:0] bidir_cs,
  output logic [NUM_BIDIR-1:0] bidir_sl,
  output logic [NUM_BIDIR-1:0] bidir_ie,
  output logic [NUM_BIDIR-1:0] bidir_pu,
  output logic [NUM_BIDIR-1:0] bidir_pd
);

  localparam int BW = $clog2(SYNC_STAGES + 2);
  localparam logic [BW-1:0] BLANK_END = BW'(SYNC_STAGES + 1);

  logic                   ready_reg, rvalid_reg;
  logic [7:0]             rdata_reg, rd_word;
  logic                   wr_acc, rd_acc, edge_en;
  logic [BW-1:0]          blank_cnt_reg;
  logic [NUM_BIDIR*8-1:0] cfg_flat;

  assign wr_acc  = reg_valid & ready_reg & reg_we;
  assign rd_acc  = reg_valid & ready_reg & ~reg_we;
  assign edge_en = (blank_cnt_reg == BLANK_END);

  // Out-of-range addresses match no pad and so read back as zero.
  always_comb begin
    rd_word = 8'h00;
    for (int i = 0; i < NUM_BIDIR; i++) begin
      if (reg_addr == ADDR_W'(i)) rd_word = cfg_flat[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_reg     <= 1'b1;
      rvalid_reg    <= 1'b0;
      rdata_reg     <= 8'h00;
      blank_cnt_reg <= '0;
    end else begin
      ready_reg  <= ~rd_acc;
      rvalid_reg <= rd_acc;
      rdata_reg  <= rd_acc ? rd_word : 8'h00;
      if (!edge_en) blank_cnt_reg <= blank_cnt_reg + 1'b1;
    end
  end

  assign reg_ready  = ready_reg;
  assign reg_rvalid = rvalid_reg;
  assign reg_rdata  = rdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BIDIR; gi++) begin : g_pad
      pad_cfg_t cfg_reg, cfg_next;
      logic     out_reg, oe_reg, cs_reg, sl_reg, ie_reg, pu_reg, pd_reg;
      logic     wr_hit;

      assign wr_hit   = wr_acc && (reg_addr == ADDR_W'(gi));
      // Drive regs load from the post-write config so a same-cycle write and
      // functional change are resolved by the new mode bit.
      assign cfg_next = wr_hit ? sanitize_cfg(reg_wdata) : cfg_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cfg_reg <= pad_cfg_t'(CFG_RESET);
          out_reg <= 1'b0;
          oe_reg  <= 1'b0;
          cs_reg  <= 1'b0;
          sl_reg  <= 1'b0;
          ie_reg  <= 1'b1;
          pu_reg  <= 1'b0;
          pd_reg  <= 1'b0;
        end else begin
          cfg_reg <= cfg_next;
          out_reg <= cfg_next.mode ? func_out[gi] : cfg_next.sw_out;
          oe_reg  <= cfg_next.mode ? func_oe[gi]  : cfg_next.sw_oe;
          cs_reg  <= cfg_next.cs;
          sl_reg  <= cfg_next.sl;
          ie_reg  <= cfg_next.ie;
          pu_reg  <= cfg_next.pu;
          pd_reg  <= cfg_next.pd;
        end
      end

      assign cfg_flat[gi*8 +: 8] = cfg_reg;
      assign bidir_out[gi] = out_reg;
      assign bidir_oe[gi]  = oe_reg;
      assign bidir_cs[gi]  = cs_reg;
      assign bidir_sl[gi]  = sl_reg;
      assign bidir_ie[gi]  = ie_reg;
      assign bidir_pu[gi]  = pu_reg;
      assign bidir_pd[gi]  = pd_reg;

      pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pad_in   (bidir_in[gi]),
        .ie       (ie_reg),
        .edge_en  (edge_en),
        .sync_out (gpio_in[gi]),
        .rise     (rise[gi]),
        .fall     (fall[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pad_ctrl.sv
// Directed bench for pad_ctrl: read responses go through a scoreboard queue,
// pad drive and edge pulses are checked inline against hand-computed values.
module tb_pad_ctrl;

  localparam int N = 54;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         reg_valid, reg_we;
  logic         reg_ready, reg_rvalid;
  logic [7:0]   reg_addr, reg_wdata, reg_rdata;
  logic [N-1:0] func_out, func_oe, gpio_in, rise, fall, bidir_in;
  logic [N-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  pad_ctrl #(.NUM_BIDIR(N), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_valid  (reg_valid),
    .reg_ready  (reg_ready),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .func_out   (func_out),
    .func_oe    (func_oe),
    .gpio_in    (gpio_in),
    .rise       (rise),
    .fall       (fall),
    .bidir_in   (bidir_in),
    .bidir_out  (bidir_out),
    .bidir_oe   (bidir_oe),
    .bidir_cs   (bidir_cs),
    .bidir_sl   (bidir_sl),
    .bidir_ie   (bidir_ie),
    .bidir_pu   (bidir_pu),
    .bidir_pd   (bidir_pd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every read response.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (reg_rvalid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid actual=1 expected=0");
          end else begin
            chk("rdata", 64'(reg_rdata), 64'(exp_q.pop_front()));
            chk("ready_during_rvalid", 64'(reg_ready), 64'd0);
          end
        end else begin
          chk("rdata_idle_zero", 64'(reg_rdata), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    $display("WR addr=%0d data=%02h", a, d);
    reg_valid = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_valid = 1'b0; reg_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    $display("RD addr=%0d expect=%02h", a, exp);
    exp_q.push_back(exp);
    reg_valid = 1'b1; reg_we = 1'b0; reg_addr = a;
    tick();
    reg_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    reg_valid = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    func_out = '0; func_oe = '0;
    bidir_in = '0;
    bidir_in[3] = 1'b1;
    repeat (3) tick();
    chk("reset_ie_all", 64'(&bidir_ie), 64'd1);
    chk("reset_oe_all", 64'(|bidir_oe), 64'd0);
    chk("reset_ready", 64'(reg_ready), 64'd1);
    chk("reset_rvalid", 64'(reg_rvalid), 64'd0);
    rst_n = 1'b1;

    // Pad 3 held high through reset: no rise pulse may leak out of blanking.
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("blank_rise3", 64'(rise[3]), 64'd0);
      if (c == 2) chk("gpio3_after_2", 64'(gpio_in[3]), 64'd1);
    end
    rd(8'd0, 8'h20);
    rd(8'd3, 8'h20);
    rd(8'd53, 8'h20);

    wr(8'd5, 8'h26);
    chk("oe5", 64'(bidir_oe[5]), 64'd1);
    chk("out5", 64'(bidir_out[5]), 64'd1);
    rd(8'd5, 8'h26);

    wr(8'd7, 8'h01);
    chk("out7_func0", 64'(bidir_out[7]), 64'd0);
    func_out[7] = 1'b1; func_oe[7] = 1'b1;
    tick();
    chk("out7_func1", 64'(bidir_out[7]), 64'd1);
    chk("oe7_func1", 64'(bidir_oe[7]), 64'd1);
    func_oe[7] = 1'b0;
    tick();
    chk("oe7_func0", 64'(bidir_oe[7]), 64'd0);

    wr(8'd2, 8'hE0);
    chk("pu2", 64'(bidir_pu[2]), 64'd0);
    chk("pd2", 64'(bidir_pd[2]), 64'd1);
    rd(8'd2, 8'hA0);

    // Pad 10 edges with ie=1, then with ie=0.
    for (int pass = 0; pass < 2; pass++) begin
      logic pe;
      pe = (pass == 0);
      bidir_in[10] = 1'b1;
      for (int c = 1; c <= 3; c++) begin
        tick();
        chk("rise10", 64'(rise[10]), 64'(pe && c == 2));
        chk("fall10_quiet", 64'(fall[10]), 64'd0);
      end
      chk("gpio10_high", 64'(gpio_in[10]), 64'd1);
      bidir_in[10] = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        tick();
        chk("fall10", 64'(fall[10]), 64'(pe && c == 2));
        chk("rise10_quiet", 64'(rise[10]), 64'd0);
      end
      chk("gpio10_low", 64'(gpio_in[10]), 64'd0);
      if (pass == 0) wr(8'd10, 8'h00);
    end

    rd(8'd60, 8'h00);
    wr(8'd54, 8'hFF);
    rd(8'd53, 8'h20);
    rd(8'd0, 8'h20);
    rd(8'd5, 8'h26);

    // Same-cycle write and functional change on pad 7: new mode (sw) wins.
    func_out[7] = 1'b1;
    wr(8'd7, 8'h00);
    chk("out7_sim", 64'(bidir_out[7]), 64'd0);
    func_out[7] = 1'b0;
    wr(8'd7, 8'h01);
    func_out[7] = 1'b1;
    tick();
    chk("out7_back_func", 64'(bidir_out[7]), 64'd1);

    // Reset lands while a read response is pending.
    $display("RD addr=5 interrupted by reset");
    reg_valid = 1'b1; reg_we = 1'b0; reg_addr = 8'd5;
    tick();
    reg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rvalid_in_reset", 64'(reg_rvalid), 64'd0);
    chk("rdata_in_reset", 64'(reg_rdata), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    rd(8'd5, 8'h20);
    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_ctrl.md
Name: pad_ctrl

Overview:
- Core-side controller for the unified bidirectional pad ring. It owns the per-pad drive and configuration signals (out, oe, cs, sl, ie, pu, pd) that the pad cells consume.
- It synchronises the pad input bus and generates per-pad rise/fall pulses.
- Each pad is either software-driven from a config register or handed to a functional core signal (func_out/func_oe).
- Sits inside chip_core between the bidir_* core ports and the functional logic and register bus.

Parameters:
- NUM_BIDIR, 54, number of bidirectional pads controlled.
- SYNC_STAGES, 2, flops in each input synchroniser (minimum 2).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- reg_valid  input  1  register request valid
- reg_ready  output  1  register request accepted when valid&&ready
- reg_we  input  1  1=write, 0=read
- reg_addr  input  8  pad index 0..NUM_BIDIR-1
- reg_wdata  input  8  config write data
- reg_rdata  output  8  read data, valid with reg_rvalid
- reg_rvalid  output  1  one-cycle read response strobe
- func_out  input  NUM_BIDIR  functional output data
- func_oe  input  NUM_BIDIR  functional output enable
- gpio_in  output  NUM_BIDIR  synchronised pad inputs
- rise  output  NUM_BIDIR  one-cycle rising-edge pulse per pad
- fall  output  NUM_BIDIR  one-cycle falling-edge pulse per pad
- bidir_in  input  NUM_BIDIR  pad Y inputs (asynchronous)
- bidir_out  output  NUM_BIDIR  pad A
- bidir_oe  output  NUM_BIDIR  pad OE
- bidir_cs  output  NUM_BIDIR  pad CS (Schmitt select)
- bidir_sl  output  NUM_BIDIR  pad SL (slew)
- bidir_ie  output  NUM_BIDIR  pad IE
- bidir_pu  output  NUM_BIDIR  pad PU
- bidir_pd  output  NUM_BIDIR  pad PD

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low; all flops clear asynchronously, release is synchronous to clk.
- Config word per pad, 8 bits: [0] mode (0=sw, 1=func), [1] sw_out, [2] sw_oe, [3] cs, [4] sl, [5] ie, [6] pu, [7] pd.
- Config reset value: 0x20 (input enabled, no drive, no pulls).
- Pad outputs are registered, so there is 1 cycle of latency from config write or func_* change to the bidir_* outputs.
  - bidir_out = mode ? func_out : sw_out
  - bidir_oe = mode ? func_oe : sw_oe
  - cs, sl, ie, pu and pd come from config in both modes.
- pu/pd conflict: if a write sets both pu and pd, the stored pu bit is forced to 0 (pd wins). Readback shows pu=0.
- Pad output reset values: bidir_out=0, oe=0, cs=0, sl=0, ie=1, pu=0, pd=0.
- Register bus:
  - reg_ready resets to 1.
  - Write accepted: config updates at the next edge; reg_ready stays 1.
  - Read accepted: in the next cycle reg_rvalid=1 and reg_rdata=config, and reg_ready=0 for that cycle only. Maximum throughput is one read per 2 cycles.
  - reg_rdata is 0 whenever reg_rvalid=0.
  - Out-of-range address (>=NUM_BIDIR): write ignored; read returns 0x00 with the normal rvalid timing.
- Input path: bidir_in passes through SYNC_STAGES flops to gpio_in, then through a prev flop.
  - rise = gpio_in & ~prev & ie
  - fall = ~gpio_in & prev & ie
  - Pulses are asserted in the same cycle gpio_in changes.
- Post-reset blanking: a counter suppresses rise/fall for the first SYNC_STAGES+1 cycles after reset release, so no spurious edge appears on pads that are high at reset.
- ie=0: gpio_in still tracks the pad pins, but rise/fall are forced 0. Clearing ie mid-pulse kills the pulse in the next cycle.
- Reset mid-read: reg_rvalid and reg_rdata drop immediately; there is no response after reset release.
- Simultaneous events: a write to pad k and a functional change on pad k in the same cycle both take effect at the next edge, resolved by the new mode bit.

Decomposition:
- pad_ctrl_pkg holds:
  - config bit-position localparams (CFG_MODE..CFG_PD);
  - CFG_RESET = 8'h20;
  - the address width;
  - a packed struct pad_cfg_t.
- Sub-module pad_sync: one instance per pad (generate loop). It contains the SYNC_STAGES synchroniser, prev flop and edge gating, and takes ie and the blanking enable as inputs.

Test Plan:
- Reset with bidir_in[3]=1 held → all configs read 0x20, bidir_ie all 1, bidir_oe all 0; gpio_in[3]=1 after 2 cycles; rise[3] never pulses.
- Write pad 5 = 0x26 (sw_oe=1, sw_out=1, ie=1) → one cycle later bidir_oe[5]=1, bidir_out[5]=1; read pad 5 → rvalid next cycle with rdata=0x26, reg_ready=0 in that cycle.
- Write pad 7 = 0x01 (func mode), toggle func_out[7] 0→1 → bidir_out[7]=1 one cycle later; func_oe[7] controls bidir_oe[7].
- Write pad 2 = 0xE0 (pu+pd) → readback 0xA0; bidir_pu[2]=0, bidir_pd[2]=1.
- Toggle bidir_in[10] 0→1→0 with ie=1 → rise[10] one cycle wide 2 cycles after the input edge, then fall[10]; repeat with ie=0 → no pulses.
- Read addr 60, write addr 54 → rdata=0x00 with rvalid; no config changes. Assert rst_n during a pending read → rvalid never seen.
